fcore_program_sequencer: RTL and testbench
==========================================

// Module: fcore_program_sequencer
// PURPOSE
//  Next-generation fCore control unit. Fetches 2-word instructions from the registered instruction store and
//  issues each one once per active channel to the decoder over a valid/ready handshake. Adds over the current
//  unit: decoder backpressure, runtime channel count up to MAX_CHANNELS, a cycle-budget watchdog, abort, fault codes.
// PARAMETERS
//  PC_WIDTH          12  instruction address width
//  INSTRUCTION_WIDTH 32  instruction word width
//  OPCODE_WIDTH      5   opcode field = instr[OPCODE_WIDTH-1:0]
//  MAX_CHANNELS      8   channels supported; CH_W = $clog2(MAX_CHANNELS) (localparam)
//  LOAD_OPCODE       8   two-word load-constant opcode
//  STOP_OPCODE       12  end-of-program opcode
//  WATCHDOG_WIDTH    24  cycle-budget counter width
// PORTS
//  clock           in   1                  core clock
//  reset           in   1                  asynchronous, active-high
//  run             in   1                  start pulse; ignored while busy
//  abort           in   1                  cancel the running program
//  n_channels      in   CH_W               active channels minus 1; latched on accepted run
//  program_size    in   16                 program length in words; latched on accepted run
//  cycle_budget    in   WATCHDOG_WIDTH     max busy cycles, 0 = watchdog off; latched on run
//  instruction_in  in   2*INSTRUCTION_WIDTH {word[pc+1], word[pc]}, valid 1 cycle after program_counter
//  program_counter out  PC_WIDTH           store read address
//  fetch_enable    out  1                  store read enable (high only in FETCH)
//  instr_data      out  INSTRUCTION_WIDTH  issued instruction word
//  instr_dest      out  CH_W               channel of the issued instruction
//  instr_valid     out  1                  issue valid
//  instr_ready     in   1                  decoder ready
//  load_data       out  INSTRUCTION_WIDTH  immediate of a LOAD_OPCODE instruction, valid with instr_valid
//  busy            out  1                  high from accepted run until DONE/FAULT/IDLE
//  done            out  1                  1-cycle pulse at normal completion
//  fault           out  1                  sticky fault flag
//  fault_code      out  2                  0 none, 1 PC overrun, 2 watchdog
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, channel counter 0, watchdog 0. Reset is asynchronous, mid-run included.
//  - States: IDLE, FETCH, WAIT, ISSUE, DONE, FAULT.
//  - IDLE: run -> FETCH, PC=0, channel=0, watchdog=0, busy=1, fault/fault_code cleared.
//  - FETCH (1 cycle): fetch_enable=1 -> WAIT.
//  - WAIT (1 cycle): capture instruction_in into instr_data/load_data -> ISSUE. Fetch latency: 2 cycles.
//  - ISSUE:
//    - STOP_OPCODE: never issued -> DONE.
//    - Otherwise: instr_valid=1 and instr_dest=channel.
//    - instr_data/dest/load_data held stable while valid & !ready.
//    - On valid & ready: if channel<n_channels, channel++ and stay in ISSUE.
//    - Else channel=0, PC += (LOAD_OPCODE ? 2 : 1), then -> FETCH.
//    - load_data is 0 for non-load instructions.
//  - PC overrun: an advance that makes new PC >= program_size -> FAULT with code 1; no fetch at the new PC.
//  - Watchdog (budget != 0): counts busy cycles, first busy cycle = 1; count == cycle_budget -> FAULT code 2.
//  - DONE: done=1 for one cycle, busy=0 -> IDLE.
//  - FAULT: fault=1, busy=0, instr_valid=0 -> IDLE. fault/fault_code stay held until the next accepted run or reset.
//  - abort (any non-IDLE state): next cycle IDLE; instr_valid drops even without ready; no done, no fault.
//  - Same-cycle priority: abort > watchdog > STOP/done > PC overrun.
//  - run is ignored while busy. run and abort together in IDLE: abort wins, stay IDLE.
//  - n_channels=0 gives single-channel issue. Channel wraps only at the latched n_channels.
// TESTING
//  1. Program ADD,LDC imm 0x3F800000,STOP; n_channels=3; ready=1
//     -> ADD dest 0..3, then LDC dest 0..3 with load_data 0x3F800000.
//     -> PC sequence 0,1,3; one done pulse; busy low afterwards.
//  2. Same program, ready toggling 1/0 each cycle
//     -> 8 issues exactly, none duplicated or lost.
//     -> instr_data/instr_dest stable while valid & !ready.
//  3. program_size=4, words 0-3 hold no STOP
//     -> fault=1, fault_code=1 on the advance to PC 4.
//     -> no done pulse; fetch_enable never asserted with PC=4.
//  4. cycle_budget=10, 20-instruction program
//     -> fault_code=2 after the 10th busy cycle; a new run clears fault and restarts at PC 0.
//  5. abort held 1 cycle during ISSUE with ready=0
//     -> IDLE next cycle, instr_valid=0, busy=0, no done; next run restarts at PC 0.
//  6. Async reset asserted mid-ISSUE between clock edges
//     -> all outputs 0 immediately; held until reset release.

Source files
------------

// File: rtl/fcore_program_sequencer.sv
// fCore program sequencer: fetches two-word instructions from the instruction store and issues
// each one once per active channel over a valid/ready handshake, with watchdog, abort and fault reporting.
module fcore_program_sequencer #(
    parameter int PC_WIDTH          = 12,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int OPCODE_WIDTH      = 5,
    parameter int MAX_CHANNELS      = 8,
    parameter int LOAD_OPCODE       = 8,
    parameter int STOP_OPCODE       = 12,
    parameter int WATCHDOG_WIDTH    = 24,
    localparam int CH_W             = $clog2(MAX_CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           run,
    input  logic                           abort,
    input  logic [CH_W-1:0]                n_channels,
    input  logic [15:0]                    program_size,
    input  logic [WATCHDOG_WIDTH-1:0]      cycle_budget,
    input  logic [2*INSTRUCTION_WIDTH-1:0] instruction_in,
    output logic [PC_WIDTH-1:0]            program_counter,
    output logic                           fetch_enable,
    output logic [INSTRUCTION_WIDTH-1:0]   instr_data,
    output logic [CH_W-1:0]                instr_dest,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    output logic [INSTRUCTION_WIDTH-1:0]   load_data,
    output logic                           busy,
    output logic                           done,
    output logic                           fault,
    output logic [1:0]                     fault_code
);

    // Extended width so PC advance overflow is still compared against program_size.
    localparam int PX_W = ((PC_WIDTH > 16) ? PC_WIDTH : 16) + 1;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DONE, S_FAULT} state_t;

    state_t                        state_q, state_d;
    logic [PC_WIDTH-1:0]           pc_q, pc_d;
    logic [CH_W-1:0]               ch_q, ch_d;
    logic [CH_W-1:0]               nch_q, nch_d;
    logic [15:0]                   size_q, size_d;
    logic [WATCHDOG_WIDTH-1:0]     budget_q, budget_d;
    logic [WATCHDOG_WIDTH-1:0]     wd_q, wd_d;
    logic [INSTRUCTION_WIDTH-1:0]  data_q, data_d;
    logic [INSTRUCTION_WIDTH-1:0]  load_q, load_d;
    logic                          valid_q, valid_d;
    logic                          fetch_q, fetch_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          fault_q, fault_d;
    logic [1:0]                    code_q, code_d;

    logic [WATCHDOG_WIDTH-1:0]     wd_inc;
    logic [PX_W-1:0]               pc_next;
    logic                          is_load;
    logic                          is_stop;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ch_d     = ch_q;
        nch_d    = nch_q;
        size_d   = size_q;
        budget_d = budget_q;
        wd_d     = wd_q;
        data_d   = data_q;
        load_d   = load_q;
        fault_d  = fault_q;
        code_d   = code_q;

        wd_inc  = wd_q + WATCHDOG_WIDTH'(1);
        is_load = (data_q[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(LOAD_OPCODE));
        is_stop = (data_q[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(STOP_OPCODE));
        pc_next = PX_W'(pc_q) + (is_load ? PX_W'(2) : PX_W'(1));

        case (state_q)
            S_IDLE: begin
                if (run && !abort) begin
                    state_d  = S_FETCH;
                    pc_d     = '0;
                    ch_d     = '0;
                    wd_d     = '0;
                    nch_d    = n_channels;
                    size_d   = program_size;
                    budget_d = cycle_budget;
                    fault_d  = 1'b0;
                    code_d   = 2'd0;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                data_d  = instruction_in[INSTRUCTION_WIDTH-1:0];
                load_d  = (instruction_in[OPCODE_WIDTH-1:0] == OPCODE_WIDTH'(LOAD_OPCODE))
                          ? instruction_in[2*INSTRUCTION_WIDTH-1:INSTRUCTION_WIDTH] : '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (is_stop) begin
                    state_d = S_DONE;
                end else if (valid_q && instr_ready) begin
                    if (ch_q < nch_q) begin
                        ch_d = ch_q + CH_W'(1);
                    end else begin
                        ch_d = '0;
                        if (pc_next >= PX_W'(size_q)) begin
                            state_d = S_FAULT;
                            code_d  = 2'd1;
                        end else begin
                            pc_d    = pc_next[PC_WIDTH-1:0];
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Watchdog overrides normal completion and PC overrun; abort overrides everything.
        if (state_q inside {S_FETCH, S_WAIT, S_ISSUE}) begin
            wd_d = wd_inc;
            if ((budget_q != '0) && (wd_inc == budget_q)) begin
                state_d = S_FAULT;
                code_d  = 2'd2;
            end
        end
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            code_d  = code_q;
        end

        fetch_d = (state_d == S_FETCH);
        busy_d  = (state_d inside {S_FETCH, S_WAIT, S_ISSUE});
        done_d  = (state_d == S_DONE);
        valid_d = (state_d == S_ISSUE) && (data_d[OPCODE_WIDTH-1:0] != OPCODE_WIDTH'(STOP_OPCODE));
        if (state_d == S_FAULT) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            ch_q     <= '0;
            nch_q    <= '0;
            size_q   <= '0;
            budget_q <= '0;
            wd_q     <= '0;
            data_q   <= '0;
            load_q   <= '0;
            valid_q  <= 1'b0;
            fetch_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            code_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ch_q     <= ch_d;
            nch_q    <= nch_d;
            size_q   <= size_d;
            budget_q <= budget_d;
            wd_q     <= wd_d;
            data_q   <= data_d;
            load_q   <= load_d;
            valid_q  <= valid_d;
            fetch_q  <= fetch_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
        end
    end

    assign program_counter = pc_q;
    assign fetch_enable    = fetch_q;
    assign instr_data      = data_q;
    assign instr_dest      = ch_q;
    assign instr_valid     = valid_q;
    assign load_data       = load_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign fault           = fault_q;
    assign fault_code      = code_q;

endmodule

// File: tb/tb_fcore_program_sequencer.sv
// Bench for fcore_program_sequencer: a registered instruction store model, a scoreboard of expected
// issues and fetch addresses built from a reference walk of each program, and a table of run scenarios.
module tb_fcore_program_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  n_channels = '0;
    logic [15:0] program_size = '0;
    logic [23:0] cycle_budget = '0;
    logic [63:0] instruction_in = '0;
    logic [11:0] program_counter;
    logic        fetch_enable;
    logic [31:0] instr_data;
    logic [2:0]  instr_dest;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] load_data;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    fcore_program_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .abort          (abort),
        .n_channels     (n_channels),
        .program_size   (program_size),
        .cycle_budget   (cycle_budget),
        .instruction_in (instruction_in),
        .program_counter(program_counter),
        .fetch_enable   (fetch_enable),
        .instr_data     (instr_data),
        .instr_dest     (instr_dest),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .load_data      (load_data),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .fault_code     (fault_code)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  dest;
        logic [31:0] ld;
    } iss_t;

    typedef struct {
        int prog;
        int nch;
        int rmode;
        int size;
        int budget;
        int exp_code;
        int exp_done;
    } vec_t;

    iss_t        exp_q[$];
    int          exp_pc[$];
    logic [31:0] mem [0:63];
    vec_t        vecs [8];
    int          tests = 0;
    int          fails = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          rdy_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Registered store: data for program_counter appears the cycle after fetch_enable.
    always @(posedge clock) begin
        if (fetch_enable)
            instruction_in <= {mem[int'(program_counter) + 1], mem[int'(program_counter)]};
    end

    initial forever begin
        @(posedge clock);
        #1;
        case (rdy_mode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = ~instr_ready;
            2:       instr_ready = 1'($urandom_range(0, 1));
            default: instr_ready = 1'b0;
        endcase
    end

    // Monitor: scoreboard pops on handshake and fetch, stability while stalled.
    initial begin
        logic        pv, pr;
        logic [31:0] pd;
        logic [2:0]  pdest;
        iss_t        e;
        int          epc;
        pv = 1'b0; pr = 1'b0; pd = '0; pdest = '0;
        forever begin
            @(negedge clock);
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            if (fetch_enable) begin
                if (exp_pc.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL fetch_unexpected: fetch at pc %0d, none required", program_counter);
                end else begin
                    epc = exp_pc.pop_front();
                    check("fetch_pc", 64'(program_counter), 64'(epc));
                end
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL issue_unexpected: data 0x%0h dest %0d, none required", instr_data, instr_dest);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_data", 64'(instr_data), 64'(e.d));
                    check("issue_dest", 64'(instr_dest), 64'(e.dest));
                    check("issue_load", 64'(load_data), 64'(e.ld));
                end
            end
            if (pv && !pr && instr_valid) begin
                check("hold_data", 64'(instr_data), 64'(pd));
                check("hold_dest", 64'(instr_dest), 64'(pdest));
            end
            pv = instr_valid; pr = instr_ready; pd = instr_data; pdest = instr_dest;
        end
    end

    task automatic load_prog(input int sel);
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        case (sel)
            0: begin
                mem[0] = 32'h0000_1561;
                mem[1] = 32'h0000_0048;
                mem[2] = 32'h3F80_0000;
                mem[3] = 32'h0000_000C;
            end
            1: for (int i = 0; i < 4; i++) mem[i] = 32'h100 + 32'(i * 32) + 32'h1;
            default: begin
                for (int i = 0; i < 20; i++) mem[i] = 32'((i + 1) * 32 + 1);
                mem[20] = 32'h0000_000C;
            end
        endcase
    endtask

    // Reference walk of the program in memory.
    task automatic build(input int nch, input int size);
        int          pc;
        logic [31:0] w;
        iss_t        e;
        pc = 0;
        forever begin
            exp_pc.push_back(pc);
            w = mem[pc];
            if (w[4:0] == 5'd12) break;
            for (int c = 0; c <= nch; c++) begin
                e.d    = w;
                e.dest = 3'(c);
                e.ld   = (w[4:0] == 5'd8) ? mem[pc + 1] : 32'h0;
                exp_q.push_back(e);
            end
            pc += (w[4:0] == 5'd8) ? 2 : 1;
            if (pc >= size) break;
        end
    endtask

    task automatic do_run(input int nch, input int size, input int budget);
        busy_cnt = 0;
        done_cnt = 0;
        @(posedge clock); #1;
        n_channels   = 3'(nch);
        program_size = 16'(size);
        cycle_budget = 24'(budget);
        run = 1'b1;
        @(posedge clock); #1;
        run = 1'b0;
        n_channels   = 3'(nch ^ 5);
        program_size = 16'd1;
        cycle_budget = 24'd2;
        check("busy_after_run", 64'(busy), 64'd1);
        check("fault_cleared", 64'(fault), 64'd0);
        check("code_cleared", 64'(fault_code), 64'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000; i++) begin
            if (!busy) break;
            @(negedge clock);
        end
        if (busy) begin
            tests++; fails++;
            $display("FAIL busy_timeout: busy still 1 after 3000 cycles, required 0");
        end
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            @(negedge clock);
        end
        check("valid_seen", 64'(instr_valid), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        load_prog(v.prog);
        build(v.nch, v.size);
        rdy_mode = v.rmode;
        do_run(v.nch, v.size, v.budget);
        wait_idle();
        check("done_pulses", 64'(done_cnt), 64'(v.exp_done));
        check("fault_flag", 64'(fault), 64'(v.exp_code != 0));
        check("fault_code", 64'(fault_code), 64'(v.exp_code));
        check("busy_low", 64'(busy), 64'd0);
        check("valid_low", 64'(instr_valid), 64'd0);
        if (v.exp_code != 2) begin
            check("issues_left", 64'(exp_q.size()), 64'd0);
            check("fetches_left", 64'(exp_pc.size()), 64'd0);
        end else begin
            check("watchdog_busy_cycles", 64'(busy_cnt), 64'(v.budget));
        end
        exp_q.delete();
        exp_pc.delete();
    endtask

    initial begin
        vecs[0] = '{0, 3, 0, 4, 0, 0, 1};
        vecs[1] = '{0, 3, 1, 4, 0, 0, 1};
        vecs[2] = '{1, 1, 0, 4, 0, 1, 0};
        vecs[3] = '{2, 0, 0, 32, 10, 2, 0};
        vecs[4] = '{0, 0, 2, 4, 0, 0, 1};
        vecs[5] = '{1, 7, 2, 4, 0, 1, 0};
        vecs[6] = '{2, 2, 1, 32, 0, 0, 1};
        vecs[7] = '{0, 3, 0, 4, 1000, 0, 1};

        #12;
        check("reset_ctrl", 64'({program_counter, fetch_enable, instr_valid, instr_dest,
                                  busy, done, fault, fault_code}), 64'd0);
        check("reset_data", {instr_data, load_data}, 64'd0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // run and abort together in IDLE: nothing starts.
        @(posedge clock); #1;
        run = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        run = 1'b0; abort = 1'b0;
        check("run_abort_idle_busy", 64'(busy), 64'd0);

        // abort during a stalled issue.
        load_prog(2);
        exp_pc.push_back(0);
        rdy_mode = 3;
        do_run(3, 32, 0);
        wait_valid();
        @(posedge clock); #1;
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_valid", 64'(instr_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_no_fault", 64'({fault, fault_code}), 64'd0);
        check("abort_fetches_left", 64'(exp_pc.size()), 64'd0);
        exp_pc.delete();
        run_vec(vecs[0]);

        // asynchronous reset between clock edges while issuing.
        load_prog(2);
        exp_pc.push_back(0);
        rdy_mode = 3;
        do_run(1, 32, 0);
        wait_valid();
        check("pre_reset_data", 64'(instr_data), 64'(mem[0]));
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        check("async_reset_ctrl", 64'({program_counter, fetch_enable, instr_valid, instr_dest,
                                        busy, done, fault, fault_code}), 64'd0);
        check("async_reset_data", {instr_data, load_data}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset_hold", 64'({instr_valid, busy, fetch_enable, program_counter}), 64'd0);
        @(negedge clock); #2;
        reset = 1'b0;
        #1;
        check("reset_release", 64'({instr_valid, busy, done, fault}), 64'd0);
        exp_pc.delete();
        exp_q.delete();
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
